// File: rtl/ctrl_biquad_pkg.sv
// Shared constants for the biquad sequencer: datapath format, select codes
// and FSM state encodings.
package ctrl_biquad_pkg;

  localparam int N = 16;
  localparam int F = 14;

  localparam logic [2:0] SEL_S_ZERO = 3'b000;
  localparam logic [2:0] SEL_S_A1   = 3'b001;
  localparam logic [2:0] SEL_S_A2   = 3'b010;
  localparam logic [2:0] SEL_S_B0   = 3'b011;
  localparam logic [2:0] SEL_S_B1   = 3'b100;
  localparam logic [2:0] SEL_S_B2   = 3'b101;

  localparam logic [1:0] SEL_C_ZERO = 2'b00;
  localparam logic [1:0] SEL_C_FK1  = 2'b01;
  localparam logic [1:0] SEL_C_FK2  = 2'b10;
  localparam logic [1:0] SEL_C_FK   = 2'b11;

  localparam logic [2:0] SEL_Z_ZERO  = 3'b000;
  localparam logic [2:0] SEL_Z_UK    = 3'b001;
  localparam logic [2:0] SEL_Z_YK    = 3'b010;
  localparam logic [2:0] SEL_Z_ACUM1 = 3'b011;
  localparam logic [2:0] SEL_Z_ACUM2 = 3'b100;
  localparam logic [2:0] SEL_Z_ACUM3 = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A1    = 3'd1,
    ST_A2    = 3'd2,
    ST_B0    = 3'd3,
    ST_B1    = 3'd4,
    ST_B2    = 3'd5,
    ST_SHIFT = 3'd6
  } state_e;

  function automatic int cnt_w(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/ctrl_biquad_step_timer.sv
// K-cycle step counter for the biquad sequencer; clears when idle and
// wraps to zero on the last cycle of each step.
module step_timer
  import ctrl_biquad_pkg::*;
#(
  parameter int K = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_start,
  output logic o_last
);

  localparam int W = cnt_w(K);
  localparam logic [W-1:0] LAST = W'(K - 1);

  logic [W-1:0] r_cnt;

  assign o_start = i_run && (r_cnt == '0);
  assign o_last  = i_run && (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_run || o_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_biquad.sv
// Five-step MAC sequencer for the time-multiplexed biquad datapath.
// Optional sticky overrun flag: define CTRL_OVERRUN_EN.
module ctrl_biquad
  import ctrl_biquad_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  output logic [2:0] controlS,
  output logic [1:0] controlC,
  output logic [2:0] controlZ,
  output logic       ld_uk,
  output logic       ld_acum1,
  output logic       ld_fk,
  output logic       ld_acum2,
  output logic       ld_acum3,
  output logic       ld_yk,
  output logic       shift_state,
  output logic       busy,
  output logic       done
`ifdef CTRL_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  state_e r_state;
  state_e w_next;
  logic   w_run;
  logic   w_start;
  logic   w_last;
  logic   w_idle;

  assign w_idle = (r_state == ST_IDLE);
  assign w_run  = (r_state != ST_IDLE) && (r_state != ST_SHIFT);

  step_timer #(
    .K(STEP_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_run  (w_run),
    .o_start(w_start),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (sample_tick) w_next = ST_A1;
      ST_A1:    if (w_last) w_next = ST_A2;
      ST_A2:    if (w_last) w_next = ST_B0;
      ST_B0:    if (w_last) w_next = ST_B1;
      ST_B1:    if (w_last) w_next = ST_B2;
      ST_B2:    if (w_last) w_next = ST_SHIFT;
      ST_SHIFT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    controlS    = SEL_S_ZERO;
    controlC    = SEL_C_ZERO;
    controlZ    = SEL_Z_ZERO;
    ld_acum1    = 1'b0;
    ld_fk       = 1'b0;
    ld_acum2    = 1'b0;
    ld_acum3    = 1'b0;
    ld_yk       = 1'b0;
    shift_state = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
      end
      ST_A1: begin
        controlS = SEL_S_A1;
        controlC = SEL_C_FK1;
        controlZ = SEL_Z_UK;
        ld_acum1 = w_last;
      end
      ST_A2: begin
        controlS = SEL_S_A2;
        controlC = SEL_C_FK2;
        controlZ = SEL_Z_ACUM1;
        ld_fk    = w_last;
      end
      ST_B0: begin
        controlS = SEL_S_B0;
        controlC = SEL_C_FK;
        controlZ = SEL_Z_ZERO;
        ld_acum2 = w_last;
      end
      ST_B1: begin
        controlS = SEL_S_B1;
        controlC = SEL_C_FK1;
        controlZ = SEL_Z_ACUM2;
        ld_acum3 = w_last;
      end
      ST_B2: begin
        controlS = SEL_S_B2;
        controlC = SEL_C_FK2;
        controlZ = SEL_Z_ACUM3;
        ld_yk    = w_last;
      end
      ST_SHIFT: begin
        shift_state = 1'b1;
        done        = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Only Mealy output; reset wins over a coincident tick
  assign ld_uk = sample_tick && w_idle && !reset;
  assign busy  = !w_idle;

`ifdef CTRL_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (sample_tick && !w_idle) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

  // Every step begins on the first cycle after a state change
  a_step_entry: assert property (
    @(posedge clk) disable iff (reset)
    w_start |-> (r_state != $past(r_state))
  );

endmodule
